debug_scan_ctl: RTL

Trigger-armed capture sequencer for the tag's serial debug port. It samples 16 internal probe signals (fifo_nextout, cmd_complete, handlematch, docrc, rx_en, tx_en, bitout, bitclk, rngbitin, rx_overflow, tx_done, txsetupdone, modout, packet_complete, plus two spare bits) into the debug_clk domain. On a selected probe edge it freezes a snapshot and shifts the snapshot out as a framed serial word. It replaces free-running address-stepped probe viewing with a coherent, single-instant snapshot.

---
 rtl/debug_scan_ctl_if.sv | 35 +++
 rtl/debug_scan_ctl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/debug_scan_ctl_if.sv
// debug_scan_ctl_if -- probe/control/serial-output bundle for debug_scan_ctl.
//
// Signals:
//   probes[15:0]  asynchronous probe bits into the sequencer
//   trig_sel[3:0] index of the trigger probe (static while armed)
//   trig_edge     0 = rising-edge trigger, 1 = falling-edge trigger
//   arm           level; enables triggering
//   single        1 = one capture per arm assertion, 0 = continuous
//   debug_out     registered serial frame bit (0 when idle)
//   frame_active  high while frame bits are driven
//   armed         high while the sequencer sits in ARMED
//   overrun       sticky; a trigger edge arrived while a frame was shifting
//
// Modports: master drives probes/controls, slave is the sequencer itself.
interface debug_scan_ctl_if;
  logic [15:0] probes;
  logic [3:0]  trig_sel;
  logic        trig_edge;
  logic        arm;
  logic        single;
  logic        debug_out;
  logic        frame_active;
  logic        armed;
  logic        overrun;

  modport master (
    output probes, trig_sel, trig_edge, arm, single,
    input  debug_out, frame_active, armed, overrun
  );

  modport slave (
    input  probes, trig_sel, trig_edge, arm, single,
    output debug_out, frame_active, armed, overrun
  );
endinterface

// File: rtl/debug_scan_ctl.sv
// debug_scan_ctl -- trigger-armed capture sequencer for the serial debug port.
//
// Synchronizes 16 probe bits into debug_clk, waits for a selected edge on one
// probe, freezes all 16 bits plus a 4-bit sequence number and shifts them out
// as one serial frame: header 1,0,1,0, snap[0..15], seq[0..3] and, when
// DEBUG_SCAN_PARITY_EN is defined, an even-parity bit over snap and seq.
//
// Ports:
//   debug_clk  rising-edge clock for all state
//   reset      asynchronous, active-high reset
//   bus        debug_scan_ctl_if.slave (probes, trigger controls, serial out)
//
// Optional feature macro: DEBUG_SCAN_PARITY_EN (adds the 25th, parity, bit).
module debug_scan_ctl (
  input  logic              debug_clk,
  input  logic              reset,
  debug_scan_ctl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, HOLD} state_t;

`ifdef DEBUG_SCAN_PARITY_EN
  localparam logic [4:0] LAST_BIT = 5'd24;
`else
  localparam logic [4:0] LAST_BIT = 5'd23;
`endif

  state_t      state, state_next;
  logic [15:0] s1, s2, s3;
  logic [15:0] snap;
  logic [3:0]  seq;
  logic [4:0]  bit_cnt;
  logic        debug_out_q, frame_active_q, armed_q, overrun_q;
  logic        s2_sel, s3_sel, edge_hit;
  logic        start_frame, end_frame;
  logic        parity_bit;
  logic [24:0] frame_vec;

  // Edge detect looks at s2/s3; s1 only absorbs metastability.
  assign s2_sel   = s2[bus.trig_sel];
  assign s3_sel   = s3[bus.trig_sel];
  assign edge_hit = bus.trig_edge ? (~s2_sel & s3_sel) : (s2_sel & ~s3_sel);

`ifdef DEBUG_SCAN_PARITY_EN
  assign parity_bit = ^{snap, seq};
`else
  assign parity_bit = 1'b0;
`endif

  // Whole frame in transmit order, bit 0 first; header 1,0,1,0 = 4'b0101.
  assign frame_vec = {parity_bit, seq, snap, 4'b0101};

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    unique case (state)
      IDLE:  if (bus.arm) state_next = ARMED;
      ARMED: begin
        // A trigger in the same cycle as disarm still gets its frame.
        if (edge_hit) begin
          state_next  = SHIFT;
          start_frame = 1'b1;
        end else if (!bus.arm) begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          end_frame = 1'b1;
          if (bus.single)   state_next = HOLD;
          else if (bus.arm) state_next = ARMED;
          else              state_next = IDLE;
        end
      end
      HOLD:  if (!bus.arm) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge debug_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge debug_clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= bus.probes;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // NOTE: the snapshot and sequence registers are reset along with the
  // control state so a truncated frame never leaks stale data afterwards.
  always_ff @(posedge debug_clk or posedge reset) begin
    if (reset) begin
      snap           <= '0;
      seq            <= '0;
      bit_cnt        <= '0;
      debug_out_q    <= 1'b0;
      frame_active_q <= 1'b0;
      armed_q        <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      armed_q <= (state_next == ARMED);

      if (state == IDLE && state_next == ARMED)
        overrun_q <= 1'b0;
      else if (state == SHIFT && edge_hit)
        overrun_q <= 1'b1;  // edge is dropped, not queued

      if (start_frame) begin
        snap           <= s2;
        seq            <= seq + 4'd1;
        bit_cnt        <= '0;
        debug_out_q    <= frame_vec[0];
        frame_active_q <= 1'b1;
      end else if (state == SHIFT) begin
        if (end_frame) begin
          bit_cnt        <= '0;
          debug_out_q    <= 1'b0;
          frame_active_q <= 1'b0;
        end else begin
          bit_cnt     <= bit_cnt + 5'd1;
          debug_out_q <= frame_vec[bit_cnt + 5'd1];
        end
      end
    end
  end

  assign bus.debug_out    = debug_out_q;
  assign bus.frame_active = frame_active_q;
  assign bus.armed        = armed_q;
  assign bus.overrun      = overrun_q;

endmodule
